// File: rtl/conv_pe_3x3x3_if.sv
// Row/weight/result bundle between the line feeder, the 3x3x3 conv PE and the
// downstream accumulation stage. data_in[0] is column 0.
interface conv_pe_if #(parameter int WIDTH = 9);
   logic                        init;
   logic [31:0][WIDTH-1:0]      data_in;
   logic [26:0][WIDTH-1:0]      weight_in;   // kernel k, row r, col c at 9k+3r+c
   logic [2:0][WIDTH-1:0]       data_out;
   logic                        out_valid;

   modport master (output init, data_in, weight_in, input data_out, out_valid);
   modport slave  (input init, data_in, weight_in, output data_out, out_valid);
endinterface

// File: rtl/conv_pe_3x3x3.sv
// 3x3 convolution PE: three 32-pixel row buffers, three kernels, one output
// column per cycle across the 30 valid positions after a 3-row load burst.

// One kernel's 9-term multiply-add with saturation to WIDTH bits.
module conv_pe_kernel #(parameter int WIDTH = 9) (
   input  logic [8:0][WIDTH-1:0] pix,
   input  logic [8:0][WIDTH-1:0] wgt,
   output logic [WIDTH-1:0]      res
);
   localparam int PW = 2*WIDTH;
   localparam int AW = 2*WIDTH+4;

   logic [AW-1:0] acc;

   always_comb begin
      acc = '0;
      for (int i = 0; i < 9; i++)
         acc = acc + AW'(PW'(pix[i]) * PW'(wgt[i]));
   end

   assign res = (acc > AW'({WIDTH{1'b1}})) ? {WIDTH{1'b1}} : acc[WIDTH-1:0];
endmodule

module conv_pe_3x3x3 #(parameter int WIDTH = 9) (
   input  logic     clk,
   input  logic     rst_n,          // active-high despite the name
   conv_pe_if.slave bus
);
   localparam logic [4:0] LAST_COL = 5'd30;

   logic [2:0][31:0][WIDTH-1:0] rows;   // [0]=top, [1]=mid, [2]=bot
   logic [8:0][WIDTH-1:0]       win;
   logic [2:0][WIDTH-1:0]       res;
   logic [2:0][WIDTH-1:0]       out_q;
   logic                        vld_q;
   logic [4:0]                  col;
   logic [1:0]                  nrows;
   logic                        init_q;
   logic                        sweep;

   // 3x3 window at the current column; col+2 never exceeds 31 while sweeping
   always_comb begin
      win = '0;
      for (int r = 0; r < 3; r++)
         for (int c = 0; c < 3; c++)
            win[3*r+c] = rows[r][col + 5'(c)];
   end

   for (genvar k = 0; k < 3; k++) begin : g_kern
      conv_pe_kernel #(.WIDTH(WIDTH)) u_kern (
         .pix (win),
         .wgt (bus.weight_in[9*k +: 9]),
         .res (res[k])
      );
   end

   assign sweep = !bus.init && (nrows == 2'd3) && (col < LAST_COL);

   always_ff @(posedge clk or posedge rst_n) begin
      if (rst_n) begin
         rows   <= '0;
         out_q  <= '0;
         vld_q  <= 1'b0;
         col    <= '0;
         nrows  <= '0;
         init_q <= 1'b0;
      end else begin
         init_q <= bus.init;
         if (bus.init) begin
            // new burst restarts the count; an in-flight sweep is abandoned
            rows  <= {bus.data_in, rows[2], rows[1]};
            nrows <= !init_q ? 2'd1 : (nrows == 2'd3 ? 2'd3 : nrows + 2'd1);
            col   <= '0;
            vld_q <= 1'b0;
         end else if (sweep) begin
            out_q <= res;
            vld_q <= 1'b1;
            col   <= col + 5'd1;
         end else begin
            vld_q <= 1'b0;
         end
      end
   end

   assign bus.data_out  = out_q;
   assign bus.out_valid = vld_q;
endmodule

// File: tb/tb_conv_pe_3x3x3.sv
// Randomised and directed bench for conv_pe_3x3x3 against an array-based model.
module tb_conv_pe_3x3x3;
   localparam int W = 9;

   logic clk = 1'b0;
   logic rst_n;
   conv_pe_if #(.WIDTH(W)) bus();

   conv_pe_3x3x3 #(.WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_fail = 0;

   // reference state
   int m_row[3][32];
   int m_out[3];
   bit m_valid;
   int m_col, m_nrows;
   bit m_init_q;

   int t_top[32], t_mid[32], t_bot[32];
   int basic_top[16] = '{1,0,0,1,1,1,2,2,1,1,0,0,1,1,2,2};
   int basic_mid[16] = '{0,0,1,1,1,2,2,1,1,0,0,1,1,2,2,1};
   int basic_bot[16] = '{0,1,1,0,2,2,1,1,0,0,1,1,2,2,1,1};

   task automatic model_reset();
      for (int r = 0; r < 3; r++) for (int i = 0; i < 32; i++) m_row[r][i] = 0;
      for (int k = 0; k < 3; k++) m_out[k] = 0;
      m_valid = 0; m_col = 0; m_nrows = 0; m_init_q = 0;
   endtask

   function automatic int conv_at(int k, int col);
      longint s = 0;
      for (int r = 0; r < 3; r++)
         for (int c = 0; c < 3; c++)
            s += longint'(m_row[r][col+c]) * longint'(bus.weight_in[9*k+3*r+c]);
      return (s > 511) ? 511 : int'(s);
   endfunction

   task automatic model_step();
      if (rst_n) begin
         model_reset();
         return;
      end
      if (bus.init) begin
         m_row[0] = m_row[1];
         m_row[1] = m_row[2];
         for (int i = 0; i < 32; i++) m_row[2][i] = int'(bus.data_in[i]);
         m_nrows = m_init_q ? ((m_nrows + 1 > 3) ? 3 : m_nrows + 1) : 1;
         m_col = 0;
         m_valid = 0;
      end else if (m_nrows == 3 && m_col < 30) begin
         for (int k = 0; k < 3; k++) m_out[k] = conv_at(k, m_col);
         m_valid = 1;
         m_col++;
      end else begin
         m_valid = 0;
      end
      m_init_q = bus.init;
   endtask

   task automatic chk(string name, int act, int exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic compare();
      chk("out_valid", int'(bus.out_valid), int'(m_valid));
      chk("data_out0", int'(bus.data_out[0]), m_out[0]);
      chk("data_out1", int'(bus.data_out[1]), m_out[1]);
      chk("data_out2", int'(bus.data_out[2]), m_out[2]);
   endtask

   // one clock: DUT and model both consume the current inputs, then compare
   task automatic cycle();
      @(posedge clk);
      model_step();
      @(negedge clk);
      compare();
   endtask

   task automatic drive_row(input int r[32]);
      for (int i = 0; i < 32; i++) bus.data_in[i] = W'(r[i]);
   endtask

   task automatic load3();
      bus.init = 1'b1;
      drive_row(t_top); cycle();
      drive_row(t_mid); cycle();
      drive_row(t_bot); cycle();
      bus.init = 1'b0;
      for (int i = 0; i < 32; i++) bus.data_in[i] = W'($urandom);
   endtask

   task automatic set_basic_rows();
      for (int i = 0; i < 32; i++) begin
         int j = (i < 16) ? i : 8 + (i % 8);
         t_top[i] = basic_top[j];
         t_mid[i] = basic_mid[j];
         t_bot[i] = basic_bot[j];
      end
      t_bot[31] = 0;
   endtask

   task automatic set_basic_weights();
      for (int k = 0; k < 3; k++)
         for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++)
               bus.weight_in[9*k+3*r+c] = W'(r + c + k);
   endtask

   task automatic lit3(string name, int a, int b, int c);
      chk({name, "_v"}, int'(bus.out_valid), 1);
      chk({name, "_0"}, int'(bus.data_out[0]), a);
      chk({name, "_1"}, int'(bus.data_out[1]), b);
      chk({name, "_2"}, int'(bus.data_out[2]), c);
   endtask

   initial begin
      int vcount;
      model_reset();
      rst_n = 1'b1;
      bus.init = 1'b0;
      for (int i = 0; i < 32; i++) bus.data_in[i] = '0;
      for (int i = 0; i < 27; i++) bus.weight_in[i] = '0;

      // reset held with random inputs
      repeat (3) begin
         bus.init = 1'($urandom);
         for (int i = 0; i < 32; i++) bus.data_in[i] = W'($urandom);
         for (int i = 0; i < 27; i++) bus.weight_in[i] = W'($urandom);
         cycle();
         chk("rst_valid", int'(bus.out_valid), 0);
      end
      rst_n = 1'b0;
      bus.init = 1'b0;

      // basic sweep
      set_basic_rows();
      set_basic_weights();
      load3();
      cycle(); lit3("basic_c0", 10, 14, 18);
      cycle(); lit3("basic_c1", 12, 17, 22);
      vcount = 2;
      repeat (30) begin
         cycle();
         if (bus.out_valid) vcount++;
      end
      chk("sweep_len", vcount, 30);
      chk("sweep_done_valid", int'(bus.out_valid), 0);

      // async reset in the middle of a sweep
      load3();
      repeat (5) cycle();
      #2 rst_n = 1'b1;
      #1 model_reset();
      compare();
      chk("async_rst_out0", int'(bus.data_out[0]), 0);
      cycle();
      rst_n = 1'b0;
      cycle();

      // short burst: two rows only
      bus.init = 1'b1;
      drive_row(t_top); cycle();
      drive_row(t_mid); cycle();
      bus.init = 1'b0;
      repeat (6) begin
         cycle();
         chk("short_valid", int'(bus.out_valid), 0);
      end

      // abort pattern: 3 loads + 1 idle, repeated
      repeat (3) begin
         load3();
         cycle(); lit3("abort_c0", 10, 14, 18);
      end
      bus.init = 1'b1;
      drive_row(t_top);
      cycle();
      chk("abort_valid", int'(bus.out_valid), 0);
      chk("abort_hold0", int'(bus.data_out[0]), 10);
      bus.init = 1'b0;
      cycle();

      // saturation
      for (int i = 0; i < 27; i++) bus.weight_in[i] = 9'd511;
      for (int i = 0; i < 32; i++) begin t_top[i] = 511; t_mid[i] = 511; t_bot[i] = 511; end
      load3();
      cycle(); lit3("sat", 511, 511, 511);
      repeat (3) cycle();

      // independence: only the centre tap of kernel 1
      set_basic_rows();
      for (int i = 0; i < 27; i++) bus.weight_in[i] = '0;
      bus.weight_in[13] = 9'd1;
      load3();
      cycle(); lit3("indep_c0", 0, 0, 0);
      cycle(); lit3("indep_c1", 0, 1, 0);
      cycle(); lit3("indep_c2", 0, 1, 0);
      repeat (30) cycle();

      // random loads, sweeps, aborts and resets
      repeat (40) begin
         int nl, ni, big;
         big = $urandom_range(0, 1);
         for (int i = 0; i < 27; i++)
            bus.weight_in[i] = W'(big ? $urandom_range(0, 511) : $urandom_range(0, 7));
         nl = $urandom_range(1, 4);
         bus.init = 1'b1;
         repeat (nl) begin
            for (int i = 0; i < 32; i++)
               bus.data_in[i] = W'(big ? $urandom_range(0, 511) : $urandom_range(0, 15));
            cycle();
         end
         bus.init = 1'b0;
         ni = $urandom_range(0, 34);
         repeat (ni) cycle();
         if ($urandom_range(0, 9) == 0) begin
            rst_n = 1'b1;
            cycle();
            rst_n = 1'b0;
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
